memory_sequence: RTL and testbench
==================================

# memory_sequence

Round sequencer for the rotating memory game, directly downstream of the 4-bit LFSR random source. Each round it captures one new 4-bit value from the random source into an internal pattern buffer, replays the whole pattern to the display logic, then checks player entries against it element by element. It reports round pass, game over or game won, and exposes the current level to the processor.

## Interface
- `MAX_LEN`, default 16: pattern capacity and winning length; legal range 1..31.
- `DISPLAY_CYCLES`, default 4: cycles each element is shown; legal range 1..255.
- `clk` in 1: single clock, all state updates on posedge.
- `clr` in 1: reset, asynchronous, active-high; clears all state.
- `random_number` in 4: value from the random source, sampled only in APPEND.
- `start` in 1: begin a new game; honoured only in IDLE.
- `player_valid` in 1: one-cycle strobe, player entry present; honoured only in INPUT.
- `player_value` in 4: player entry, qualified by `player_valid`.
- `display_valid` out 1: `display_value` is to be shown this cycle.
- `display_value` out 4: pattern element being shown; 0 when `display_valid`=0.
- `awaiting_input` out 1: high throughout INPUT.
- `level` out 5: number of elements in the current pattern.
- `round_pass` out 1: one-cycle pulse, round entered correctly.
- `game_over` out 1: one-cycle pulse, wrong entry.
- `game_won` out 1: one-cycle pulse, `MAX_LEN` round passed.

## Operation
- Registered state: FSM state, buffer of `MAX_LEN` x 4 bits, `len` (5 bits), `idx` (5 bits), display timer (8 bits). All outputs are decoded from registered state.
- States and transitions:
  - IDLE: on `start`, set `len`=0 and go to APPEND.
  - APPEND: write `buf[len]` <= `random_number`, `len` <= `len`+1, `idx` <= 0, timer <= 0, then go to SHOW. This is exactly one cycle.
  - SHOW: `display_valid`=1, `display_value`=`buf[idx]`. Timer counts up; when timer = `DISPLAY_CYCLES`-1, clear the timer and go to GAP.
  - GAP: one cycle with `display_valid`=0. If `idx`=`len`-1, set `idx` <= 0 and go to INPUT. Otherwise increment `idx` and go to SHOW.
  - INPUT: `awaiting_input`=1. On `player_valid`:
    - If `player_value`=`buf[idx]` and `idx`=`len`-1, go to PASS.
    - If it matches and `idx`<`len`-1, increment `idx`.
    - If it does not match, go to FAIL.
  - PASS: one cycle, `round_pass`=1. If `len`=`MAX_LEN`, also `game_won`=1 and go to IDLE. Otherwise go to APPEND.
  - FAIL: one cycle, `game_over`=1, then go to IDLE.
- `level` equals `len` at all times. It holds its last value in IDLE after a game ends, and is cleared only by `clr` or by a new `start`.
- The buffer is not cleared by `start`. Entries at index ≥ `len` are never read.
- `start` outside IDLE is ignored. `player_valid` outside INPUT is ignored and is not queued.
- The value 0 on `random_number` is stored and compared like any other value.

## Timing
- Reset values: state IDLE, `len`=0, `idx`=0, timer=0. All outputs are 0.
- `clr` mid-operation (including SHOW or INPUT) returns everything to reset values immediately. No pulse output fires.
- `start` sampled at edge N puts the block in APPEND during cycle N+1. `random_number` is captured at the end of that cycle, and the first SHOW cycle is N+2.
- Display phase of a round with length L: L x (`DISPLAY_CYCLES`+1) cycles, the last being a GAP. INPUT starts on the following cycle.
- Each INPUT entry is decided on the edge where `player_valid` is sampled. PASS or FAIL is visible on the next cycle, for one cycle.
- Between rounds: PASS (1 cycle), then APPEND (1 cycle), then SHOW.

## Test plan
- Reset: assert `clr` for 3 cycles with `start`=1. Require IDLE, all outputs 0, `level`=0, and `start` has no effect until `clr` is deasserted.
- Round 1, `DISPLAY_CYCLES`=4, `random_number`=9: pulse `start`. Require `display_valid`=1 with value 9 for 4 cycles, 1 gap, then `awaiting_input`=1. Enter 9: `round_pass` pulses once and `level`=1.
- Round 2, `random_number`=3 during APPEND: require display 9 then 3, each 4 cycles plus a gap. Enter 9, 3: `round_pass` pulses and `level`=2.
- Wrong entry in round 2, entering 9 then 5: `game_over` pulses once, the block returns to IDLE, `level` stays 2, and a later `player_valid` is ignored.
- Win, `MAX_LEN`=3: pass 3 rounds. On round 3, `round_pass` and `game_won` pulse in the same cycle, then IDLE. A new `start` sets `level` to 1 after APPEND.
- Reset mid-operation: assert `clr` during SHOW of round 2 and again during INPUT. Require immediate IDLE, `display_valid`=0, `level`=0, and no pulses.

Source files
------------

// File: rtl/memory_sequence_if.sv
// Signal bundle between the round sequencer and its environment: random source,
// player entry, display output and game status.
interface memory_sequence_if;
  logic [3:0] random_number;
  logic       start;
  logic       player_valid;
  logic [3:0] player_value;
  logic       display_valid;
  logic [3:0] display_value;
  logic       awaiting_input;
  logic [4:0] level;
  logic       round_pass;
  logic       game_over;
  logic       game_won;

  modport master (
    output random_number, start, player_valid, player_value,
    input  display_valid, display_value, awaiting_input, level,
    input  round_pass, game_over, game_won
  );

  modport slave (
    input  random_number, start, player_valid, player_value,
    output display_valid, display_value, awaiting_input, level,
    output round_pass, game_over, game_won
  );
endinterface

// File: rtl/memory_sequence.sv
// Round sequencer for the rotating memory game: grows a random pattern by one element
// per round, replays it to the display, then checks the player's entries against it.
module memory_sequence #(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned DISPLAY_CYCLES = 4
) (
  input logic               clk,
  input logic               clr,
  memory_sequence_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StAppend,
    StShow,
    StGap,
    StInput,
    StPass,
    StFail
  } state_e;

  localparam int unsigned IdxW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [4:0]  MaxLen   = 5'(MAX_LEN);
  localparam logic [7:0]  LastTick = 8'(DISPLAY_CYCLES - 1);

  state_e     state_q, state_d;
  logic [4:0] len_q, len_d;
  logic [4:0] idx_q, idx_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] pat_q [MAX_LEN];
  logic       pat_we;
  logic [3:0] cur_val;
  logic       last_idx;

  // idx and len never exceed MAX_LEN-1 when used as indices, so the low bits suffice.
  assign cur_val  = pat_q[idx_q[IdxW-1:0]];
  assign last_idx = (idx_q == len_q - 5'd1);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      len_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        pat_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      if (pat_we) begin
        pat_q[len_q[IdxW-1:0]] <= bus.random_number;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    pat_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          len_d   = '0;
          state_d = StAppend;
        end
      end
      StAppend: begin
        pat_we  = 1'b1;
        len_d   = len_q + 5'd1;
        idx_d   = '0;
        timer_d = '0;
        state_d = StShow;
      end
      StShow: begin
        if (timer_q == LastTick) begin
          timer_d = '0;
          state_d = StGap;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StGap: begin
        if (last_idx) begin
          idx_d   = '0;
          state_d = StInput;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = StShow;
        end
      end
      StInput: begin
        if (bus.player_valid) begin
          if (bus.player_value != cur_val) begin
            state_d = StFail;
          end else if (last_idx) begin
            state_d = StPass;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      StPass: begin
        state_d = (len_q == MaxLen) ? StIdle : StAppend;
      end
      StFail: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.display_valid  = (state_q == StShow);
  assign bus.display_value  = (state_q == StShow) ? cur_val : 4'd0;
  assign bus.awaiting_input = (state_q == StInput);
  assign bus.level          = len_q;
  assign bus.round_pass     = (state_q == StPass);
  assign bus.game_won       = (state_q == StPass) && (len_q == MaxLen);
  assign bus.game_over      = (state_q == StFail);

endmodule

// File: tb/tb_memory_sequence.sv
// Directed bench for memory_sequence: reset, display timing, entry checking, win,
// wrong entry and asynchronous clear during display and input.
module tb_memory_sequence;

  localparam int DispCycles = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [3:0] exp_pat [$];

  memory_sequence_if bus ();

  memory_sequence #(
    .MAX_LEN        (3),
    .DISPLAY_CYCLES (DispCycles)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // All display and pulse outputs low, plus the expected level.
  task automatic check_quiet(input string tag, input logic [4:0] lvl);
    check({tag, "_outs"}, {bus.display_valid, bus.display_value, bus.awaiting_input,
                           bus.round_pass, bus.game_over, bus.game_won}, 32'h0);
    check({tag, "_level"}, bus.level, lvl);
  endtask

  // Called in IDLE; returns in the first SHOW cycle.
  task automatic start_game(input logic [3:0] rn);
    bus.start = 1'b1;
    bus.random_number = rn;
    step();
    bus.start = 1'b0;
    check("append_level0", bus.level, 5'd0);
    check("append_no_disp", bus.display_valid, 1'b0);
    step();
    check("first_show_level", bus.level, 5'd1);
    exp_pat = {};
    exp_pat.push_back(rn);
  endtask

  // Called in PASS; returns in the first SHOW cycle of the next round.
  task automatic next_round(input logic [3:0] rn);
    bus.random_number = rn;
    step();
    check("append_no_pulse", bus.round_pass, 1'b0);
    check("append_no_disp", bus.display_valid, 1'b0);
    step();
    exp_pat.push_back(rn);
    check("show_level", bus.level, 5'(exp_pat.size()));
  endtask

  // Called in the first SHOW cycle; returns in the first INPUT cycle.
  task automatic show_pattern();
    foreach (exp_pat[i]) begin
      for (int c = 0; c < DispCycles; c++) begin
        check("show_valid", bus.display_valid, 1'b1);
        check("show_value", bus.display_value, exp_pat[i]);
        check("show_no_input", bus.awaiting_input, 1'b0);
        step();
      end
      check("gap_valid", bus.display_valid, 1'b0);
      check("gap_value", bus.display_value, 4'd0);
      step();
    end
    check("input_await", bus.awaiting_input, 1'b1);
  endtask

  task automatic enter(input logic [3:0] v);
    bus.player_valid = 1'b1;
    bus.player_value = v;
    step();
    bus.player_valid = 1'b0;
  endtask

  initial begin
    bus.start = 1'b1;
    bus.random_number = 4'd0;
    bus.player_valid = 1'b0;
    bus.player_value = 4'd0;

    // Reset held with start asserted
    #1;
    for (int i = 0; i < 3; i++) begin
      check_quiet("reset", 5'd0);
      step();
    end
    check_quiet("reset_end", 5'd0);
    bus.start = 1'b0;
    clr = 1'b0;
    step();
    check_quiet("post_reset", 5'd0);
    step();
    check_quiet("post_reset2", 5'd0);

    // Round 1: pattern 9
    start_game(4'd9);
    show_pattern();
    enter(4'd9);
    check("r1_pass", bus.round_pass, 1'b1);
    check("r1_not_won", bus.game_won, 1'b0);
    check("r1_level", bus.level, 5'd1);

    // Round 2: pattern 9,3
    next_round(4'd3);
    show_pattern();
    enter(4'd9);
    check("r2_mid_await", bus.awaiting_input, 1'b1);
    check("r2_mid_no_pass", bus.round_pass, 1'b0);
    enter(4'd3);
    check("r2_pass", bus.round_pass, 1'b1);
    check("r2_not_won", bus.game_won, 1'b0);
    check("r2_level", bus.level, 5'd2);

    // Round 3 with a zero element: final round wins
    next_round(4'd0);
    show_pattern();
    enter(4'd9);
    enter(4'd3);
    enter(4'd0);
    check("r3_pass", bus.round_pass, 1'b1);
    check("r3_won", bus.game_won, 1'b1);
    check("r3_level", bus.level, 5'd3);
    step();
    check_quiet("won_idle", 5'd3);
    enter(4'd9);
    check_quiet("won_idle_entry", 5'd3);

    // New game: wrong entry in round 2
    start_game(4'd9);
    show_pattern();
    enter(4'd9);
    check("g2_r1_pass", bus.round_pass, 1'b1);
    next_round(4'd3);
    show_pattern();
    enter(4'd9);
    enter(4'd5);
    check("fail_over", bus.game_over, 1'b1);
    check("fail_no_pass", bus.round_pass, 1'b0);
    check("fail_level", bus.level, 5'd2);
    step();
    check_quiet("fail_idle", 5'd2);
    enter(4'd3);
    check_quiet("fail_ignored", 5'd2);
    step();
    check_quiet("fail_not_queued", 5'd2);

    // Clear during SHOW of round 2
    start_game(4'd5);
    show_pattern();
    enter(4'd5);
    check("g3_r1_pass", bus.round_pass, 1'b1);
    next_round(4'd6);
    step();
    check("clr_show_pre", bus.display_valid, 1'b1);
    clr = 1'b1;
    #1;
    check_quiet("clr_show", 5'd0);
    #1;
    clr = 1'b0;
    step();
    check_quiet("clr_show_after", 5'd0);

    // Clear during INPUT
    start_game(4'd5);
    show_pattern();
    clr = 1'b1;
    #1;
    check_quiet("clr_input", 5'd0);
    #1;
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet("clr_input_after", 5'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
